// File: rtl/gate_bist_pkg.sv
// Shared definitions for the basic-gates BIST controller: FSM states,
// gate output bit positions and sweep size.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE
    } bist_state_e;

    localparam int unsigned GATE_AND  = 0;
    localparam int unsigned GATE_OR   = 1;
    localparam int unsigned GATE_NOT  = 2;
    localparam int unsigned GATE_NAND = 3;
    localparam int unsigned GATE_NOR  = 4;
    localparam int unsigned GATE_XOR  = 5;
    localparam int unsigned GATE_XNOR = 6;

    localparam int unsigned NUM_GATES   = 7;
    localparam int unsigned NUM_VECTORS = 4;

endpackage

// File: rtl/gate_golden_model.sv
// Reference outputs of the seven basic gates for one {a,b} vector,
// kept separate from the gate block under test.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic [1:0]           vec_i,
    output logic [NUM_GATES-1:0] exp_o
);

    logic a;
    logic b;

    assign a = vec_i[1];
    assign b = vec_i[0];

    always_comb begin
        exp_o            = '0;
        exp_o[GATE_AND]  = a & b;
        exp_o[GATE_OR]   = a | b;
        exp_o[GATE_NOT]  = ~a;
        exp_o[GATE_NAND] = ~(a & b);
        exp_o[GATE_NOR]  = ~(a | b);
        exp_o[GATE_XOR]  = a ^ b;
        exp_o[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST sequencer: sweeps all {a,b} vectors through the gate block, compares
// sampled outputs to the golden model and reports sticky failure status.
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    output logic                 dut_a,
    output logic                 dut_b,
    input  logic [NUM_GATES-1:0] dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] fail_mask,
    output logic [ERR_W-1:0]     err_count
);

    localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PAS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [PAS_W-1:0] PAS_LAST = PAS_W'(NUM_PASSES - 1);
    localparam logic [1:0]       IDX_LAST = 2'(NUM_VECTORS - 1);

    bist_state_e          state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [PAS_W-1:0]     pcnt_q, pcnt_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [NUM_GATES-1:0] sample_q, sample_d;
    logic [NUM_GATES-1:0] fail_mask_q, fail_mask_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 pass_q, pass_d;

    logic [NUM_GATES-1:0] golden;
    logic [NUM_GATES-1:0] mismatch;
    logic                 last_vec;

    gate_golden_model u_golden (
        .vec_i (idx_q),
        .exp_o (golden)
    );

    assign mismatch = sample_q ^ golden;
    assign last_vec = (idx_q == IDX_LAST) && (pcnt_q == PAS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start) state_d = ST_APPLY;
            ST_APPLY:  if (abort) state_d = ST_IDLE;
                       else if (settle_q == SET_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = abort ? ST_IDLE : ST_CHECK;
            ST_CHECK:  if (abort) state_d = ST_IDLE;
                       else state_d = last_vec ? ST_DONE : ST_APPLY;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Vector pins are gated in IDLE so idx need not be cleared after a run.
    always_comb begin
        busy  = (state_q != ST_IDLE);
        done  = (state_q == ST_DONE) && !abort;
        dut_a = (state_q != ST_IDLE) && idx_q[1];
        dut_b = (state_q != ST_IDLE) && idx_q[0];
    end

    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_q;

    always_comb begin
        idx_d       = idx_q;
        pcnt_d      = pcnt_q;
        settle_d    = settle_q;
        sample_d    = sample_q;
        fail_mask_d = fail_mask_q;
        err_d       = err_q;
        pass_d      = pass_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d       = '0;
                    pcnt_d      = '0;
                    settle_d    = '0;
                    fail_mask_d = '0;
                    err_d       = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_APPLY: settle_d = (settle_q == SET_LAST) ? '0 : settle_q + SET_W'(1);
            ST_SAMPLE: sample_d = dut_out;
            ST_CHECK: begin
                fail_mask_d = fail_mask_q | mismatch;
                if ((|mismatch) && (err_q != '1)) err_d = err_q + ERR_W'(1);
                if (!last_vec) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == IDX_LAST) pcnt_d = pcnt_q + PAS_W'(1);
                end
            end
            ST_DONE: pass_d = (fail_mask_q == '0);
            default: ;
        endcase
        // Abort keeps the partial mask/count but never reports a pass.
        if (abort && (state_q != ST_IDLE)) begin
            fail_mask_d = fail_mask_q;
            err_d       = err_q;
            settle_d    = '0;
            pass_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            pcnt_q      <= '0;
            settle_q    <= '0;
            sample_q    <= '0;
            fail_mask_q <= '0;
            err_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            pcnt_q      <= pcnt_d;
            settle_q    <= settle_d;
            sample_q    <= sample_d;
            fail_mask_q <= fail_mask_d;
            err_q       <= err_d;
            pass_q      <= pass_d;
        end
    end

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: two instances (defaults, and ERR_W=2/NUM_PASSES=3)
// driving a behavioural gate block with selectable faults.
module tb_gate_bist_ctrl;

    localparam int unsigned SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    int         fault0 = 0;
    int         fault1 = 0;
    int         edge_cnt = 0;
    int         total = 0;
    int         bad = 0;

    wire [1:0] dut_a_w, dut_b_w, busy_w, done_w, pass_w;
    wire [6:0] gout0, gout1, fm0, fm1;
    wire [3:0] err0;
    wire [1:0] err1;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Gate block under test; fault 1: xor stuck-0, 2: not wired as ~b, 3: all stuck-0.
    function automatic logic [6:0] gate_blk(input int fault, input logic a, input logic b);
        logic [6:0] o;
        o = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
        if (fault == 1) o[5] = 1'b0;
        if (fault == 2) o[2] = ~b;
        if (fault == 3) o = '0;
        return o;
    endfunction

    assign gout0 = gate_blk(fault0, dut_a_w[0], dut_b_w[0]);
    assign gout1 = gate_blk(fault1, dut_a_w[1], dut_b_w[1]);

    gate_bist_ctrl u_dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]),
        .dut_a(dut_a_w[0]), .dut_b(dut_b_w[0]), .dut_out(gout0),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .fail_mask(fm0), .err_count(err0)
    );

    gate_bist_ctrl #(.SETTLE_CYCLES(SETTLE), .NUM_PASSES(3), .ERR_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]),
        .dut_a(dut_a_w[1]), .dut_b(dut_b_w[1]), .dut_out(gout1),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .fail_mask(fm1), .err_count(err1)
    );

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h at t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int np_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction
    function automatic int ew_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction
    function automatic int run_len(input int i);
        return 4 * np_of(i) * (SETTLE + 2);
    endfunction

    // Truth tables indexed by {a,b}: and, or, not(~a), nand, nor, xor, xnor.
    function automatic logic [6:0] golden_tt(input int v);
        logic [3:0] tt [7];
        logic [6:0] o;
        tt = '{4'b1000, 4'b1110, 4'b0011, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        for (int g = 0; g < 7; g++) o[g] = tt[g][v];
        return o;
    endfunction

    function automatic int vec_at(input int i, input int t);
        if (t >= run_len(i)) return 3;
        return (t / (SETTLE + 2)) % 4;
    endfunction

    function automatic logic [6:0] vec_mm(input int i, input int v);
        logic [1:0] vb;
        vb = 2'(v);
        return gate_blk((i == 0) ? fault0 : fault1, vb[1], vb[0]) ^ golden_tt(v);
    endfunction

    bit         m_run  [2] = '{0, 0};
    int         m_t    [2] = '{0, 0};
    logic [6:0] m_mask [2] = '{7'h0, 7'h0};
    int         m_errs [2] = '{0, 0};
    bit         m_pass [2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] = 0; m_t[i] = 0; m_mask[i] = '0; m_errs[i] = 0; m_pass[i] = 0;
            end else if (!m_run[i]) begin
                if (start_v[i]) begin
                    m_run[i] = 1; m_t[i] = 0; m_mask[i] = '0; m_errs[i] = 0; m_pass[i] = 0;
                end
            end else if (abort_v[i]) begin
                m_run[i] = 0; m_pass[i] = 0;
            end else if (m_t[i] == run_len(i)) begin
                m_run[i] = 0; m_pass[i] = (m_mask[i] == '0);
            end else begin
                if (m_t[i] % (SETTLE + 2) == SETTLE + 1) begin
                    logic [6:0] mm;
                    mm = vec_mm(i, vec_at(i, m_t[i]));
                    m_mask[i] = m_mask[i] | mm;
                    if (mm != '0) m_errs[i]++;
                end
                m_t[i]++;
            end
        end
    end

    task automatic cmp_inst(input int i, input logic bz, input logic dn, input logic a, input logic b,
                            input logic [6:0] fm, input logic [31:0] er, input logic ps);
        int v, cap, e_err;
        logic [1:0] vb;
        v = vec_at(i, m_t[i]);
        vb = 2'(v);
        cap = (1 << ew_of(i)) - 1;
        e_err = (m_errs[i] < cap) ? m_errs[i] : cap;
        check("busy", i, 32'(bz), 32'(m_run[i]));
        check("done", i, 32'(dn), 32'(m_run[i] && m_t[i] == run_len(i) && !abort_v[i]));
        check("dut_a", i, 32'(a), 32'(m_run[i] && vb[1]));
        check("dut_b", i, 32'(b), 32'(m_run[i] && vb[0]));
        check("fail_mask", i, 32'(fm), 32'(m_mask[i]));
        check("err_count", i, er, 32'(e_err));
        check("pass", i, 32'(ps), 32'(m_pass[i]));
    endtask

    always @(negedge clk) begin
        cmp_inst(0, busy_w[0], done_w[0], dut_a_w[0], dut_b_w[0], fm0, 32'(err0), pass_w[0]);
        cmp_inst(1, busy_w[1], done_w[1], dut_a_w[1], dut_b_w[1], fm1, 32'(err1), pass_w[1]);
    end

    // ---------------- directed stimulus ----------------
    task automatic run_and_wait(input int i, output int lat, output int bcnt);
        int k;
        bit seen;
        @(posedge clk); #1 start_v[i] = 1'b1;
        k = edge_cnt;
        @(posedge clk); #1 start_v[i] = 1'b0;
        bcnt = 0; seen = 0; lat = -1;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (busy_w[i]) bcnt++;
            if (done_w[i]) begin
                seen = 1;
                lat = edge_cnt - k;
            end
        end
        if (!seen) check("done_timeout", i, 32'(seen), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int lat, bcnt, dcnt;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 0, 32'(busy_w), 32'd0);
        check("rst_dut_ab", 0, 32'({dut_a_w, dut_b_w}), 32'd0);
        check("rst_mask", 0, 32'(fm0), 32'd0);
        check("rst_err", 0, 32'(err0), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: clean gate block
        run_and_wait(0, lat, bcnt);
        check("t1_latency", 0, 32'(lat), 32'd17);
        check("t1_busy_cycles", 0, 32'(bcnt), 32'd17);
        check("t1_pass", 0, 32'(pass_w[0]), 32'd1);
        check("t1_mask", 0, 32'(fm0), 32'h00);
        check("t1_err", 0, 32'(err0), 32'd0);
        check("t1_idle", 0, 32'(busy_w[0]), 32'd0);

        // 2: xor stuck-at-0
        fault0 = 1;
        run_and_wait(0, lat, bcnt);
        check("t2_mask", 0, 32'(fm0), 32'h20);
        check("t2_err", 0, 32'(err0), 32'd2);
        check("t2_pass", 0, 32'(pass_w[0]), 32'd0);

        // 3: not wired as ~b
        fault0 = 2;
        run_and_wait(0, lat, bcnt);
        check("t3_mask", 0, 32'(fm0), 32'h04);
        check("t3_err", 0, 32'(err0), 32'd2);
        check("t3_pass", 0, 32'(pass_w[0]), 32'd0);

        // 4: three passes, all outputs stuck-at-0, 2-bit saturating counter
        fault1 = 3;
        run_and_wait(1, lat, bcnt);
        check("t4_latency", 1, 32'(lat), 32'd49);
        check("t4_mask", 1, 32'(fm1), 32'h7F);
        check("t4_err", 1, 32'(err1), 32'd3);
        check("t4_pass", 1, 32'(pass_w[1]), 32'd0);

        // 5: start ignored while busy, then abort 6 cycles after start
        fault0 = 0;
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 abort_v[0] = 1'b1;
        check("t5_busy_before", 0, 32'(busy_w[0]), 32'd1);
        @(posedge clk); #1 abort_v[0] = 1'b0;
        check("t5_busy", 0, 32'(busy_w[0]), 32'd0);
        check("t5_dut_ab", 0, 32'({dut_a_w[0], dut_b_w[0]}), 32'd0);
        check("t5_pass", 0, 32'(pass_w[0]), 32'd0);
        dcnt = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done_w[0]) dcnt++;
        end
        check("t5_no_done", 0, 32'(dcnt), 32'd0);

        // 6: async reset in the first CHECK cycle, then a clean rerun
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("t6_busy", 0, 32'(busy_w[0]), 32'd0);
        check("t6_done", 0, 32'(done_w[0]), 32'd0);
        check("t6_dut_ab", 0, 32'({dut_a_w[0], dut_b_w[0]}), 32'd0);
        check("t6_mask", 0, 32'(fm0), 32'd0);
        check("t6_err", 0, 32'(err0), 32'd0);
        check("t6_pass", 0, 32'(pass_w[0]), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        run_and_wait(0, lat, bcnt);
        check("t6_latency", 0, 32'(lat), 32'd17);
        check("t6_rerun_pass", 0, 32'(pass_w[0]), 32'd1);
        check("t6_rerun_mask", 0, 32'(fm0), 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 want=0");
        $fatal(1, "timeout");
    end

endmodule
